// File: rtl/fft64_pkg.sv
// Shared types for the FFT stream controller: frame tag entry, FSM state, frame length.
package fft64_pkg;

    localparam int N_PTS = 64;
    localparam int SEQ_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_RUN
    } fft_state_e;

    typedef struct packed {
        logic             bubble;
        logic [SEQ_W-1:0] seq;
        logic             err;
    } fft_tag_t;

    localparam fft_tag_t BUBBLE_TAG = '{bubble: 1'b1, seq: '0, err: 1'b0};

endpackage

// File: rtl/fft64_stream_ctrl_if.sv
// Sample stream into the controller (valid/ready) and re-framed bin stream out (valid only).
// master = upstream source / downstream sink side, slave = the controller.
interface fft64_stream_ctrl_if #(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_W      = fft64_pkg::SEQ_W
);
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;
    logic [DATA_WIDTH-1:0] s_re;
    logic [DATA_WIDTH-1:0] s_im;
    logic                  m_valid;
    logic                  m_last;
    logic [DATA_WIDTH-1:0] m_re;
    logic [DATA_WIDTH-1:0] m_im;
    logic [TAG_W-1:0]      m_tag;
    logic                  m_err;

    modport master (
        output s_valid, s_last, s_re, s_im,
        input  s_ready,
        input  m_valid, m_last, m_re, m_im, m_tag, m_err
    );

    modport slave (
        input  s_valid, s_last, s_re, s_im,
        output s_ready,
        output m_valid, m_last, m_re, m_im, m_tag, m_err
    );
endinterface

// File: rtl/fft64_tag_fifo.sv
// Show-ahead FIFO of frame tags; push visible at head one cycle later.
// No backpressure: push when full is dropped unless a pop frees the slot, pop when empty is ignored.
module fft64_tag_fifo
    import fft64_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic     clk,
    input  logic     clear,
    input  logic     push,
    input  fft_tag_t push_tag,
    input  logic     pop,
    output fft_tag_t head,
    output logic     full,
    output logic     empty
);
    localparam int AW = $clog2(DEPTH);

    fft_tag_t        mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !clear) begin
            mem[wr_ptr] <= push_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/fft64_stream_ctrl.sv
// Feeds the SDF FFT core one sample per slot (bubble/zero-padding as needed) and re-frames its output.
// Core input 1 cycle after acceptance, output 1 cycle after core; s_ready backpressures, output has none.
module fft64_stream_ctrl
    import fft64_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int TAG_W      = SEQ_W,
    parameter int TAG_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fft64_stream_ctrl_if.slave    io,
    output logic                  core_rst_n,
    output logic                  core_start,
    output logic [DATA_WIDTH-1:0] core_din_re,
    output logic [DATA_WIDTH-1:0] core_din_im,
    input  logic [DATA_WIDTH-1:0] core_dout_re,
    input  logic [DATA_WIDTH-1:0] core_dout_im,
    input  logic                  core_valid_out,
    output logic                  sync_err
);
    localparam logic [5:0] LAST_SLOT = 6'(N_PTS - 1);

    fft_state_e       state;
    logic [5:0]       slot;
    logic             frame_bubble;
    logic             frame_done;
    logic             frame_err;
    logic [SEQ_W-1:0] seq;
    logic             core_run;
    logic [5:0]       out_cnt;
    fft_tag_t         cur_tag;
    fft_tag_t         push_tag;
    fft_tag_t         head_tag;
    fft_tag_t         frame_tag;
    logic             clear;
    logic             accept;
    logic             push;
    logic             pop;
    logic             tag_full;
    logic             tag_empty;

    assign clear      = rst || flush;
    assign accept     = io.s_valid && io.s_ready;
    assign core_rst_n = core_run && !clear;

    // Frame closes at slot 63; a real frame is in error unless it ended cleanly with s_last here or earlier.
    assign push     = (state != ST_IDLE) && (slot == LAST_SLOT);
    assign push_tag = '{bubble: frame_bubble,
                        seq:    seq,
                        err:    !frame_bubble &&
                                (frame_err || !(frame_done || (accept && io.s_last)))};

    assign pop       = core_valid_out && (out_cnt == '0);
    assign frame_tag = !pop ? cur_tag : (tag_empty ? BUBBLE_TAG : head_tag);

    fft64_tag_fifo #(
        .DEPTH (TAG_DEPTH)
    ) u_tag_fifo (
        .clk      (clk),
        .clear    (clear),
        .push     (push),
        .push_tag (push_tag),
        .pop      (pop),
        .head     (head_tag),
        .full     (tag_full),
        .empty    (tag_empty)
    );

    always_ff @(posedge clk) begin
        if (clear) begin
            state        <= ST_IDLE;
            slot         <= '0;
            frame_bubble <= 1'b0;
            frame_done   <= 1'b0;
            frame_err    <= 1'b0;
            seq          <= '0;
            core_run     <= 1'b0;
            core_start   <= 1'b0;
            core_din_re  <= '0;
            core_din_im  <= '0;
            io.s_ready   <= 1'b1;
        end else begin
            core_din_re <= accept ? io.s_re : '0;
            core_din_im <= accept ? io.s_im : '0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state        <= ST_FILL;
                        slot         <= 6'd1;
                        core_run     <= 1'b1;
                        core_start   <= 1'b1;
                        frame_bubble <= 1'b0;
                        frame_done   <= io.s_last;
                        frame_err    <= io.s_last;
                        io.s_ready   <= !io.s_last;
                    end
                end
                default: begin
                    slot <= slot + 6'd1;
                    if (slot == LAST_SLOT) begin
                        state      <= ST_RUN;
                        io.s_ready <= 1'b1;
                        if (!frame_bubble) begin
                            seq <= seq + 1'b1;
                        end
                    end else if (slot == '0) begin
                        // No beat at slot 0 makes the whole frame a bubble.
                        frame_bubble <= !accept;
                        frame_done   <= !accept || io.s_last;
                        frame_err    <= accept && io.s_last;
                        io.s_ready   <= accept && !io.s_last;
                    end else if (!frame_done) begin
                        if (!accept) begin
                            frame_err <= 1'b1;
                        end else if (io.s_last) begin
                            frame_done <= 1'b1;
                            frame_err  <= 1'b1;
                            io.s_ready <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            out_cnt    <= '0;
            cur_tag    <= '0;
            io.m_valid <= 1'b0;
            io.m_last  <= 1'b0;
            io.m_re    <= '0;
            io.m_im    <= '0;
            io.m_tag   <= '0;
            io.m_err   <= 1'b0;
        end else if (core_valid_out) begin
            out_cnt    <= out_cnt + 6'd1;
            cur_tag    <= frame_tag;
            io.m_valid <= !frame_tag.bubble;
            io.m_last  <= !frame_tag.bubble && (out_cnt == LAST_SLOT);
            if (!frame_tag.bubble) begin
                io.m_re  <= core_dout_re;
                io.m_im  <= core_dout_im;
                io.m_tag <= TAG_W'(frame_tag.seq);
                io.m_err <= frame_tag.err;
            end
        end else begin
            io.m_valid <= 1'b0;
            io.m_last  <= 1'b0;
        end
    end

    // Sticky across flush so a framing slip stays visible to software.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_err <= 1'b0;
        end else if (!flush && ((push && tag_full && !(pop && !tag_empty)) || (pop && tag_empty))) begin
            sync_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fft64_stream_ctrl.sv
// Randomized bench: a delay-line stand-in for the FFT core echoes each frame, so the output must equal the framed input.
module tb_fft64_stream_ctrl;
    import fft64_pkg::*;

    localparam int DW = 16;
    localparam int TW = 8;
    localparam int CL = 66;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush;
    logic          core_rst_n;
    logic          core_start;
    logic [DW-1:0] core_din_re, core_din_im;
    logic [DW-1:0] core_dout_re, core_dout_im;
    logic          core_valid_out;
    logic          sync_err;

    fft64_stream_ctrl_if #(.DATA_WIDTH(DW), .TAG_W(TW)) io ();

    fft64_stream_ctrl #(.DATA_WIDTH(DW), .TAG_W(TW), .TAG_DEPTH(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .io             (io),
        .core_rst_n     (core_rst_n),
        .core_start     (core_start),
        .core_din_re    (core_din_re),
        .core_din_im    (core_din_im),
        .core_dout_re   (core_dout_re),
        .core_dout_im   (core_dout_im),
        .core_valid_out (core_valid_out),
        .sync_err       (sync_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [TW-1:0] tag;
        logic          err;
        logic          last;
    } exp_t;

    int n_checks;
    int n_errors;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model of the framing rules.
    exp_t          exp_q[$];
    bit            m_run;
    int            m_slot;
    bit            m_bubble, m_done, m_err;
    int            m_seq;
    logic [DW-1:0] fr_re[64], fr_im[64];
    bit            exp_ready;
    logic [DW-1:0] exp_din_re, exp_din_im;

    // Core stand-in: pure CL-cycle delay line, cleared while its reset is low.
    logic          pv[CL];
    logic [DW-1:0] pre[CL], pim[CL];
    logic          cap_rst_n, cap_start;
    logic [DW-1:0] cap_re, cap_im;

    // Source state.
    int src_idx, src_len;
    bit pending;

    function automatic int pick_len(input int short_pct);
        if ($urandom_range(0, 99) < short_pct) return $urandom_range(1, 90);
        return 64;
    endfunction

    task automatic model_step(input bit acc, input bit clr,
                              input logic [DW-1:0] re, input logic [DW-1:0] im, input logic last);
        if (clr) begin
            m_run = 0; m_slot = 0; m_seq = 0;
            exp_q.delete();
            exp_din_re = '0; exp_din_im = '0;
            exp_ready = 1;
            return;
        end
        exp_din_re = acc ? re : '0;
        exp_din_im = acc ? im : '0;
        if (!m_run && !acc) begin
            exp_ready = 1;
            return;
        end
        if (!m_run) begin
            m_run = 1; m_slot = 0;
        end
        if (m_slot == 0) begin
            m_bubble = !acc; m_done = 0; m_err = 0;
        end
        fr_re[m_slot] = acc ? re : '0;
        fr_im[m_slot] = acc ? im : '0;
        if (!m_bubble) begin
            if (!acc && !m_done) m_err = 1;
            if (acc && last) begin
                m_done = 1;
                if (m_slot != 63) m_err = 1;
            end
        end
        if (m_slot == 63) begin
            if (!m_bubble) begin
                if (!m_done) m_err = 1;
                for (int j = 0; j < 64; j++)
                    exp_q.push_back('{fr_re[j], fr_im[j], TW'(m_seq), m_err, j == 63});
                m_seq = (m_seq + 1) % 256;
            end
            m_slot = 0;
        end else begin
            m_slot++;
        end
        exp_ready = (m_slot == 0) || !(m_bubble || m_done);
    endtask

    task automatic core_step();
        if (!cap_rst_n) begin
            for (int i = 0; i < CL; i++) begin
                pv[i] = 1'b0; pre[i] = '0; pim[i] = '0;
            end
        end else begin
            for (int i = CL - 1; i > 0; i--) begin
                pv[i] = pv[i-1]; pre[i] = pre[i-1]; pim[i] = pim[i-1];
            end
            pv[0] = cap_start; pre[0] = cap_re; pim[0] = cap_im;
        end
        core_valid_out = pv[CL-1];
        core_dout_re   = pre[CL-1];
        core_dout_im   = pim[CL-1];
    endtask

    task automatic check_output();
        exp_t e;
        if (exp_q.size() == 0) begin
            check_eq("m_valid_idle", io.m_valid, 1'b0);
        end else if (io.m_valid) begin
            e = exp_q.pop_front();
            check_eq("m_data", {io.m_re, io.m_im}, {e.re, e.im});
            check_eq("m_tag", io.m_tag, e.tag);
            check_eq("m_err", io.m_err, e.err);
            check_eq("m_last", io.m_last, e.last);
        end
        check_eq("m_last_no_valid", io.m_last & ~io.m_valid, 1'b0);
    endtask

    // Called #1 after a rising edge; ends #1 after the next one.
    task automatic cycle(input bit do_rst, input bit do_flush, input int vpct, input int short_pct);
        bit acc;
        check_eq("s_ready", io.s_ready, exp_ready);
        check_eq("core_start", core_start, m_run);
        check_eq("core_din", {core_din_re, core_din_im}, {exp_din_re, exp_din_im});
        check_eq("sync_err", sync_err, 1'b0);
        check_output();

        rst   = do_rst;
        flush = do_flush;
        if (!pending) begin
            io.s_valid = ($urandom_range(0, 99) < vpct);
            io.s_re    = DW'($urandom);
            io.s_im    = DW'($urandom);
            io.s_last  = (src_idx == src_len - 1);
        end
        #1;
        check_eq("core_rst_n", core_rst_n, m_run && !do_rst && !do_flush);
        cap_rst_n = core_rst_n;
        cap_start = core_start;
        cap_re    = core_din_re;
        cap_im    = core_din_im;
        acc = io.s_valid && exp_ready && !do_rst && !do_flush;

        @(posedge clk);
        model_step(acc, do_rst || do_flush, io.s_re, io.s_im, io.s_last);
        if (do_rst || do_flush) begin
            src_idx = 0; src_len = pick_len(short_pct); pending = 0;
        end else if (acc) begin
            pending = 0;
            if (io.s_last) begin
                src_idx = 0; src_len = pick_len(short_pct);
            end else begin
                src_idx++;
            end
        end else begin
            pending = io.s_valid;
        end
        #1;
        core_step();
    endtask

    int ph_cyc[5]   = '{400, 600, 600, 600, 17000};
    int ph_vpct[5]  = '{100, 90, 60, 100, 99};
    int ph_short[5] = '{0, 20, 30, 30, 5};

    initial begin
        n_checks = 0; n_errors = 0;
        rst = 1'b1; flush = 1'b0;
        io.s_valid = 1'b0; io.s_last = 1'b0; io.s_re = '0; io.s_im = '0;
        core_valid_out = 1'b0; core_dout_re = '0; core_dout_im = '0;
        cap_rst_n = 1'b0; cap_start = 1'b0; cap_re = '0; cap_im = '0;
        model_step(1'b0, 1'b1, '0, '0, 1'b0);
        src_idx = 0; src_len = 64; pending = 0;

        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_s_ready", io.s_ready, 1'b1);
        check_eq("rst_m_valid", io.m_valid, 1'b0);
        check_eq("rst_m_last", io.m_last, 1'b0);
        check_eq("rst_m_data", {io.m_re, io.m_im}, '0);
        check_eq("rst_m_tag", io.m_tag, '0);
        check_eq("rst_m_err", io.m_err, 1'b0);
        check_eq("rst_core_rst_n", core_rst_n, 1'b0);
        check_eq("rst_core_start", core_start, 1'b0);
        check_eq("rst_core_din", {core_din_re, core_din_im}, '0);
        check_eq("rst_sync_err", sync_err, 1'b0);
        core_step();

        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < ph_cyc[p]; c++) begin
                cycle((p == 3) && (c == 0),
                      ((p == 2) && (c == 0)) || ((p == 3) && (c == 0)) || ((p == 4) && (c == 300)),
                      ph_vpct[p], ph_short[p]);
            end
        end
        for (int c = 0; c < 400; c++) cycle(1'b0, 1'b0, 0, 0);
        check_eq("drain_remaining", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
